aes_core_scheduler: RTL and testbench
=====================================

AES_CORE_SCHEDULER -- requirements
Module: aes_core_scheduler

Interface
REQ-001 The block SHALL have parameter NR, default 10, giving the AES rounds per block (1..15).
REQ-002 The block SHALL have parameter CPR, default 5, giving the cycles spent per round (>=1).
REQ-003 The block SHALL have parameter LDC, default 4, giving the key/data load cycles (>=2).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port req, input, 2 bits, per-requester encryption request, level-sensitive.
REQ-007 The block SHALL have port gnt, output, 2 bits, one-hot core ownership, held for the whole transaction.
REQ-008 The block SHALL have port rsp_valid, output, 2 bits, result-ready flag to the owning requester.
REQ-009 The block SHALL have port rsp_ready, input, 2 bits, requester acceptance of its result.
REQ-010 The block SHALL have port core_accept, output, 1 bit, core load strobe for key/plaintext.
REQ-011 The block SHALL have port core_ks_select, output, 1 bit, core key-schedule source select (1 = external key).
REQ-012 The block SHALL have port core_rnd, output, 4 bits, current round number to the core.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE -> LOAD -> ROUND -> RESP -> IDLE only.
REQ-015 In IDLE with req != 0, the block SHALL grant req[ptr] if set, else the other requester, and enter LOAD next cycle with gnt set.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs 0.
REQ-017 LOAD SHALL last exactly LDC cycles with core_accept=1, core_ks_select=1 on load cycles 0..LDC-2 and 0 on the last, and core_rnd=0.
REQ-018 ROUND SHALL set core_rnd=1 on entry, hold each value CPR cycles, increment by 1, and leave after round NR's CPR cycles, with core_accept=0 and core_ks_select=0.
REQ-019 RESP SHALL assert rsp_valid[owner] only, set core_rnd=0, and hold until rsp_ready[owner]=1.
REQ-020 On the RESP handshake, the block SHALL clear gnt and rsp_valid the next cycle, set ptr to the non-owner, and return to IDLE.
REQ-021 A new grant SHALL NOT issue in the handshake cycle; minimum one IDLE cycle between transactions.
REQ-022 Deassertion of req[owner] mid-transaction SHALL be ignored, with no abort, and the transaction completes normally.
REQ-023 rsp_ready on a non-owner bit or outside RESP SHALL be ignored.
REQ-024 Latency SHALL be rsp_valid high exactly 1+LDC+NR*CPR cycles after the IDLE cycle that sampled req (55 at defaults).
REQ-025 The round counter SHALL be 4 bits and the cycle counter ceil(log2(max(CPR,LDC))) bits; neither SHALL wrap within a transaction.
REQ-026 gnt, rsp_valid, core_* and busy SHALL all be registered outputs.

Reset
REQ-027 With rst=1 at a clock edge, the next cycle SHALL have state=IDLE, ptr=0, and all counters and outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it, produce no rsp_valid, and give the next grant to requester 0 on simultaneous requests.

Structure
REQ-029 The state encoding, NR/CPR/LDC defaults and the round-counter width SHALL live in shared package aes_pkg.
REQ-030 The round-robin pick SHALL be sub-module aes_rr_arb2, which is combinational and takes inputs req and ptr and outputs a one-hot grant.
REQ-031 Total RTL SHALL be 120-400 lines.

Verification
REQ-032 The bench SHALL drive req=01 from reset -> gnt=01 next cycle; core_accept high 4 cycles with core_ks_select 1,1,1,0; core_rnd steps 1..10 every 5 cycles; rsp_valid=01 at cycle 55.
REQ-033 The bench SHALL drive req=11 after reset -> requester 0 is served first; after handshake and one IDLE cycle, gnt=10.
REQ-034 The bench SHALL hold rsp_ready low 20 cycles in RESP -> rsp_valid held, core_rnd=0, gnt unchanged; handshake then gives IDLE next cycle.
REQ-035 The bench SHALL assert rst at core_rnd=6 -> next cycle all outputs 0 and busy=0; no rsp_valid ever for that transaction.
REQ-036 The bench SHALL drop req[owner] during ROUND and pulse rsp_ready[non-owner] -> the transaction completes with rsp_valid to the owner at cycle 55 and no effect from the stray ready.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES core scheduler: FSM encoding, default
// timing parameters and counter sizing.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int NR_DEFAULT  = 10;  // AES rounds per block
    localparam int CPR_DEFAULT = 5;   // cycles per round
    localparam int LDC_DEFAULT = 4;   // key/data load cycles

    // Round number fits 1..15, so 4 bits are always enough.
    localparam int RND_W = 4;

    // Cycle-counter width: must count 0..max(CPR,LDC)-1 without wrapping.
    function automatic int cnt_width(input int cpr, input int ldc);
        int m;
        m = (cpr > ldc) ? cpr : ldc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin pick: the requester named by ptr wins if it is asking,
// otherwise the other one. Purely combinational, one-hot (or zero) grant.
module aes_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // Priority follows ptr; grant stays zero when nobody requests.
    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one iterative AES core between two requesters. Each transaction
// loads key/data for LDC cycles, runs NR rounds of CPR cycles each, then
// presents the result until the owner accepts it.
module aes_core_scheduler
    import aes_pkg::*;
#(
    parameter int NR  = NR_DEFAULT,
    parameter int CPR = CPR_DEFAULT,
    parameter int LDC = LDC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic             core_accept,
    output logic             core_ks_select,
    output logic [RND_W-1:0] core_rnd,
    output logic             busy
);

    localparam int CNT_W = cnt_width(CPR, LDC);

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LDC - 1);
    localparam logic [CNT_W-1:0] LOAD_PENULT = CNT_W'(LDC - 2);
    localparam logic [CNT_W-1:0] ROUND_LAST  = CNT_W'(CPR - 1);
    localparam logic [RND_W-1:0] RND_LAST    = RND_W'(NR);

    state_t           state_q;
    logic             ptr_q;
    logic [CNT_W-1:0] cyc_q;
    logic [RND_W-1:0] rnd_q;
    logic [1:0]       gnt_q;
    logic [1:0]       rsp_valid_q;
    logic             core_accept_q;
    logic             core_ks_select_q;
    logic             busy_q;

    logic [1:0]       arb_grant;
    logic             handshake;

    aes_rr_arb2 u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // Only the owner's ready bit can complete a transaction.
    assign handshake = |(rsp_ready & gnt_q);

    // Scheduler FSM; every output is computed one cycle ahead and registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state_q          <= ST_IDLE;
            ptr_q            <= 1'b0;
            cyc_q            <= '0;
            rnd_q            <= '0;
            gnt_q            <= 2'b00;
            rsp_valid_q      <= 2'b00;
            core_accept_q    <= 1'b0;
            core_ks_select_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q          <= ST_LOAD;
                        gnt_q            <= arb_grant;
                        cyc_q            <= '0;
                        core_accept_q    <= 1'b1;
                        // LDC >= 2, so load cycle 0 is never the last one.
                        core_ks_select_q <= 1'b1;
                        busy_q           <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (cyc_q == LOAD_LAST) begin
                        state_q          <= ST_ROUND;
                        cyc_q            <= '0;
                        rnd_q            <= RND_W'(1);
                        core_accept_q    <= 1'b0;
                        core_ks_select_q <= 1'b0;
                    end else begin
                        cyc_q            <= cyc_q + CNT_W'(1);
                        // External key on every load cycle except the final one.
                        core_ks_select_q <= (cyc_q != LOAD_PENULT);
                    end
                end

                ST_ROUND: begin
                    if (cyc_q == ROUND_LAST) begin
                        cyc_q <= '0;
                        if (rnd_q == RND_LAST) begin
                            state_q     <= ST_RESP;
                            rnd_q       <= '0;
                            rsp_valid_q <= gnt_q;
                        end else begin
                            rnd_q <= rnd_q + RND_W'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (handshake) begin
                        state_q     <= ST_IDLE;
                        gnt_q       <= 2'b00;
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        // Hand priority to the requester that was not served.
                        ptr_q       <= gnt_q[0];
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign rsp_valid      = rsp_valid_q;
    assign core_accept    = core_accept_q;
    assign core_ks_select = core_ks_select_q;
    assign core_rnd       = rnd_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler at default parameters
// (NR=10, CPR=5, LDC=4 -> response 55 cycles after the sampling IDLE cycle).
module tb_aes_core_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic       core_accept;
    logic       core_ks_select;
    logic [3:0] core_rnd;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    aes_core_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .core_accept    (core_accept),
        .core_ks_select (core_ks_select),
        .core_rnd       (core_rnd),
        .busy           (busy)
    );

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
        logic [1:0] rsp_valid;
        logic       acc;
        logic       ks;
        logic [3:0] rnd;
        logic       busy;
    } vec_t;

    vec_t vecs[13];

    // Output bundle: {gnt, rsp_valid, core_accept, core_ks_select, core_rnd, busy}
    function automatic logic [10:0] pack(input logic [1:0] g, input logic [1:0] v,
                                         input logic a, input logic k,
                                         input logic [3:0] r, input logic b);
        return {g, v, a, k, r, b};
    endfunction

    function automatic logic [10:0] outs();
        return {gnt, rsp_valid, core_accept, core_ks_select, core_rnd, busy};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        bit seen;

        // Transaction with owner 0: hand-computed checkpoints.
        vecs[0]  = '{1,  2'b01, 2'b00, 1'b1, 1'b1, 4'd0,  1'b1};
        vecs[1]  = '{2,  2'b01, 2'b00, 1'b1, 1'b1, 4'd0,  1'b1};
        vecs[2]  = '{3,  2'b01, 2'b00, 1'b1, 1'b1, 4'd0,  1'b1};
        vecs[3]  = '{4,  2'b01, 2'b00, 1'b1, 1'b0, 4'd0,  1'b1};
        vecs[4]  = '{5,  2'b01, 2'b00, 1'b0, 1'b0, 4'd1,  1'b1};
        vecs[5]  = '{9,  2'b01, 2'b00, 1'b0, 1'b0, 4'd1,  1'b1};
        vecs[6]  = '{10, 2'b01, 2'b00, 1'b0, 1'b0, 4'd2,  1'b1};
        vecs[7]  = '{14, 2'b01, 2'b00, 1'b0, 1'b0, 4'd2,  1'b1};
        vecs[8]  = '{15, 2'b01, 2'b00, 1'b0, 1'b0, 4'd3,  1'b1};
        vecs[9]  = '{50, 2'b01, 2'b00, 1'b0, 1'b0, 4'd10, 1'b1};
        vecs[10] = '{54, 2'b01, 2'b00, 1'b0, 1'b0, 4'd10, 1'b1};
        vecs[11] = '{55, 2'b01, 2'b01, 1'b0, 1'b0, 4'd0,  1'b1};
        vecs[12] = '{56, 2'b01, 2'b01, 1'b0, 1'b0, 4'd0,  1'b1};

        rst       = 1'b1;
        req       = 2'b00;
        rsp_ready = 2'b00;
        cyc       = 0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", outs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));

        // Sequence 1: single requester 0, req dropped after the grant.
        req = 2'b01;
        cyc = 0;
        for (int i = 0; i < 13; i++) begin
            while (cyc < vecs[i].cyc) begin
                tick();
                if (cyc == 1) req = 2'b00;
            end
            check($sformatf("seq1_cyc%0d", vecs[i].cyc), outs(),
                  pack(vecs[i].gnt, vecs[i].rsp_valid, vecs[i].acc, vecs[i].ks,
                       vecs[i].rnd, vecs[i].busy));
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("seq1_handshake_idle", outs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));

        // Sequence 2: both request; requester 0 first, stalled response, then requester 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        cyc = 0;
        tick();
        check("seq2_first_gnt", outs(), pack(2'b01, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1));
        run_to(54);
        check("seq2_cyc54", outs(), pack(2'b01, 2'b00, 1'b0, 1'b0, 4'd10, 1'b1));
        tick();
        check("seq2_rsp_cyc55", outs(), pack(2'b01, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) rsp_ready = 2'b10;
            tick();
            rsp_ready = 2'b00;
            check($sformatf("seq2_hold%0d", i), outs(),
                  pack(2'b01, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1));
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("seq2_handshake_idle", outs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        tick();
        check("seq2_second_gnt", outs(), pack(2'b10, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1));

        // Sequence 3: reset while requester 1 is at round 6.
        for (int i = 0; i < 100 && core_rnd != 4'd6; i++) tick();
        check("seq3_reach_rnd6", {7'd0, core_rnd}, 11'd6);
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        check("seq3_after_reset", outs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid != 2'b00 || busy) seen = 1'b1;
        end
        check("seq3_no_rsp_after_reset", {10'd0, seen}, 11'd0);

        // Sequence 4: grant after reset goes to 0; owner drops req, stray readies ignored.
        req = 2'b11;
        cyc = 0;
        tick();
        check("seq4_gnt_after_reset", outs(), pack(2'b01, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1));
        req = 2'b10;
        while (cyc < 54) begin
            if (cyc == 20)      rsp_ready = 2'b10;
            else if (cyc == 30) rsp_ready = 2'b01;
            else                rsp_ready = 2'b00;
            tick();
        end
        rsp_ready = 2'b00;
        check("seq4_cyc54", outs(), pack(2'b01, 2'b00, 1'b0, 1'b0, 4'd10, 1'b1));
        rsp_ready = 2'b10;
        tick();
        check("seq4_rsp_cyc55", outs(), pack(2'b01, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1));
        tick();
        check("seq4_stray_ready_resp", outs(), pack(2'b01, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1));
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        check("seq4_handshake_idle", outs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        tick();
        check("seq4_next_gnt", outs(), pack(2'b10, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
